// File: rtl/local_store_pipe_pkg.sv
// Shared types and constants for the local-store load/store pipe.
// Effective-address helpers return byte addresses with the low nibble cleared.
package local_store_pipe_pkg;

  typedef enum logic [2:0] {
    LS_NOP = 3'd0,
    LQD    = 3'd1,
    LQA    = 3'd2,
    STQD   = 3'd3,
    STQA   = 3'd4
  } ls_op_t;

  localparam logic [2:0] LS_UNIT_ID = 3'd6;
  localparam int         LS_LATENCY = 7;
  localparam int         QUADWORD   = 128;
  localparam int         RT_W       = 7;

  function automatic logic [31:0] d_form_addr(input logic [31:0] ra, input logic [9:0] imm);
    return ({{18{imm[9]}}, imm, 4'b0000} + ra) & 32'hFFFF_FFF0;
  endfunction

  function automatic logic [31:0] a_form_addr(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00} & 32'hFFFF_FFF0;
  endfunction

  function automatic logic is_load(input ls_op_t op);
    return (op == LQD) || (op == LQA);
  endfunction

  function automatic logic is_store(input ls_op_t op);
    return (op == STQD) || (op == STQA);
  endfunction

endpackage

// File: rtl/ls_memory.sv
// Single-port synchronous quadword store: one write or one registered read per edge.
module ls_memory #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int WIDTH  = 128
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the storage maps to RAM.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ls_shift_reg.sv
// Flushable valid/payload shift register; payload only moves with a valid so outputs hold.
module ls_shift_reg #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 8,
  parameter int TAP_W = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic [DEPTH-1:0]            valid,
  output logic [DEPTH-1:0][TAP_W-1:0] tap,
  output logic [WIDTH-1:0]            out_data
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0]            prev_valid;
  logic [DEPTH-1:0][WIDTH-1:0] prev_data;

  always_comb begin
    prev_valid[0] = in_valid;
    prev_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      prev_valid[i] = valid[i-1];
      prev_data[i]  = stage[i-1];
    end
  end

  // NOTE: state updates use non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      stage <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid[i] <= prev_valid[i] && !flush;
        if (prev_valid[i] && !flush) stage[i] <= prev_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) tap[i] = stage[i][TAP_W-1:0];
    out_data = stage[DEPTH-1];
  end

endmodule

// File: rtl/local_store_pipe.sv
// Local-store load/store pipe: address generation, quadword store, fixed-latency
// flushable load pipeline with per-stage target visibility for hazard checks.
module local_store_pipe
  import local_store_pipe_pkg::*;
#(
  parameter int LS_ADDR_W = 15,
  parameter int LATENCY   = LS_LATENCY,
  parameter int DATA_W    = QUADWORD
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  ls_op_t                  issue_op,
  input  logic [31:0]             ra_word,
  input  logic [9:0]              i10,
  input  logic [15:0]             i16,
  input  logic [RT_W-1:0]         rt_addr,
  input  logic [DATA_W-1:0]       rt_data,
  input  logic                    flush,
  output logic                    result_valid,
  output logic [RT_W-1:0]         result_rt_addr,
  output logic [DATA_W-1:0]       result_data,
  output logic [2:0]              result_unit_id,
  output logic [LATENCY-1:0]      inflight_valid,
  output logic [RT_W*LATENCY-1:0] inflight_rt
);

  localparam int LINE_W   = LS_ADDR_W - 4;
  localparam int LS_DEPTH = 2 ** LINE_W;
  localparam int CHAIN    = LATENCY - 1;

  if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
    $error("LATENCY must be in 2..8");
  end

  logic [31:0]             ea;
  logic [LINE_W-1:0]       line;
  logic                    accept, do_load, do_store;
  logic                    we, re;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    valid0;
  logic [RT_W-1:0]         rt0;
  logic [CHAIN-1:0]        chain_valid;
  logic [CHAIN-1:0][RT_W-1:0] chain_tap;
  logic [DATA_W+RT_W-1:0]  chain_out;

  always_comb begin
    ea       = (issue_op == LQD || issue_op == STQD) ? d_form_addr(ra_word, i10) : a_form_addr(i16);
    line     = LINE_W'(ea >> 4);
    accept   = issue_valid && !flush;
    do_load  = accept && is_load(issue_op);
    do_store = accept && is_store(issue_op);
    // A store meeting its edge while reset is held must not reach the unreset array.
    we       = do_store && reset;
    re       = do_load && reset;
  end

  ls_memory #(
    .DEPTH (LS_DEPTH),
    .ADDR_W(LINE_W),
    .WIDTH (DATA_W)
  ) u_mem (
    .clock(clock),
    .we   (we),
    .re   (re),
    .addr (line),
    .wdata(rt_data),
    .rdata(mem_rdata)
  );

  // Stage 0 tracks the load alongside the memory read register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid0 <= 1'b0;
      rt0    <= '0;
    end else begin
      valid0 <= do_load;
      if (do_load) rt0 <= rt_addr;
    end
  end

  ls_shift_reg #(
    .DEPTH(CHAIN),
    .WIDTH(DATA_W + RT_W),
    .TAP_W(RT_W)
  ) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .in_valid(valid0),
    .in_data ({mem_rdata, rt0}),
    .valid   (chain_valid),
    .tap     (chain_tap),
    .out_data(chain_out)
  );

  always_comb begin
    result_valid                  = chain_valid[CHAIN-1];
    {result_data, result_rt_addr} = chain_out;
    result_unit_id                = result_valid ? LS_UNIT_ID : 3'd0;
    inflight_valid                = {chain_valid, valid0};
    inflight_rt[RT_W-1:0]         = rt0;
    for (int k = 1; k < LATENCY; k++) inflight_rt[k*RT_W +: RT_W] = chain_tap[k-1];
  end

endmodule

// File: doc/local_store_pipe.md
LOCAL_STORE_PIPE -- requirements
Module: local_store_pipe

Interface
REQ-001 Parameter LS_ADDR_W, default 15, byte-address width of the local store; LS_DEPTH = 2**(LS_ADDR_W-4) quadword lines.
REQ-002 Parameter LATENCY, default 7, issue-to-result cycles for loads; legal range 2..8.
REQ-003 Parameter DATA_W, default 128, quadword width.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 issue_valid  in  1  operation presented this cycle.
REQ-007 issue_op  in  ls_op_t  LS_NOP, LQD, LQA, STQD, STQA.
REQ-008 ra_word  in  32  preferred word of RA (D-form base).
REQ-009 i10  in  10  D-form immediate; i16  in  16  A-form immediate.
REQ-010 rt_addr  in  7  target/source register number.
REQ-011 rt_data  in  DATA_W  store data (RT value).
REQ-012 flush  in  1  branch-mispredict kill of in-flight loads.
REQ-013 result_valid  out  1; result_rt_addr  out  7; result_data  out  DATA_W; result_unit_id  out  3.
REQ-014 inflight_valid  out  LATENCY; inflight_rt  out  7*LATENCY  per-stage load targets for dispatch hazard checks.

Function
REQ-015 D-form address SHALL be (sign-extend(i10)<<4 + ra_word) with low 4 bits cleared, truncated to LS_ADDR_W bits (modulo wrap).
REQ-016 A-form address SHALL be (sign-extend(i16)<<2) with low 4 bits cleared, truncated to LS_ADDR_W bits.
REQ-017 Line index SHALL be address bits above bit 3 (LS_ADDR_W-4 bits); no misalignment fault exists.
REQ-018 Store SHALL write rt_data to the line at the first rising edge after its issue cycle (edge E1).
REQ-019 Load SHALL read the line at its E1; a load issued the cycle after a store to the same line SHALL return the stored data.
REQ-020 Load data SHALL traverse LATENCY-1 pipeline registers; result_valid SHALL assert for exactly one cycle, LATENCY cycles after the issue cycle, with result_rt_addr = issuing rt_addr, result_unit_id = LS_UNIT_ID.
REQ-021 Stores and LS_NOP SHALL never assert result_valid.
REQ-022 One operation per cycle accepted, no stall; back-to-back loads SHALL produce back-to-back results.
REQ-023 flush SHALL clear every in-flight load stage valid at the next edge; loads already at the result stage in the flush cycle are still presented that cycle.
REQ-024 issue_valid with flush in the same cycle: the issuing operation SHALL be discarded, including stores (no memory write).
REQ-025 Stores committed before flush SHALL NOT be undone.
REQ-026 inflight_valid[k]/inflight_rt[k] SHALL reflect load stage k (k=0 is E1 stage) each cycle.
REQ-027 result_data SHALL hold its last value when result_valid is low.

Reset
REQ-028 reset low SHALL immediately clear all stage valids, result_valid, inflight_valid; result_rt_addr, result_data, result_unit_id SHALL be 0.
REQ-029 Memory contents SHALL NOT be reset; reset mid-operation drops all in-flight loads; a store whose E1 coincides with reset assertion is not written.

Structure
REQ-030 ls_op_t, LS_UNIT_ID (3'd6), LS_LATENCY default and QUADWORD width SHALL live in package descriptions.
REQ-031 Storage SHALL be a sub-module ls_memory: single-port, synchronous, LS_DEPTH x DATA_W, write-enable and read-enable, unreset array.
REQ-032 Pipeline valid/rt_addr/data chain SHALL be a parametrised shift register of depth LATENCY-1.

Verification
REQ-033 STQA i16=0x0010 data=0xA5.. repeated, next cycle LQA i16=0x0010 rt=5 -> result_valid 7 cycles after load issue, rt 5, data 0xA5.. repeated.
REQ-034 STQD ra_word=0x7FF0 i10=0x001 data=D -> written at address 0x0000 (wrap); LQA i16=0 returns D.
REQ-035 Eight back-to-back LQA to lines 0..7 -> eight consecutive result_valid cycles, in order, correct rt_addr.
REQ-036 Three loads in flight, flush at cycle 3 -> no results for them; a store issued with flush leaves target line unchanged.
REQ-037 reset asserted with 4 loads in flight -> outputs 0 immediately, no results after release; prior memory data still readable.
REQ-038 LATENCY=2 and LATENCY=8 builds rerun REQ-033 -> result exactly 2 and 8 cycles after issue.
